// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM states, NOP encoding and word geometry for the instruction memory loader.
package imem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  function automatic int bytes_per_word(input int xlen);
    return xlen / 8;
  endfunction
endpackage

// File: rtl/imem_byte_assembler.sv
// imem_byte_assembler: packs a little-endian byte stream into words, strobing wr on a full word or last byte.
module imem_byte_assembler import imem_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            accept,
  input  logic [7:0]      data,
  input  logic            last,
  output logic [XLEN-1:0] word,
  output logic            wr
);
  localparam int BW = bytes_per_word(XLEN);
  localparam int IW = BW > 1 ? $clog2(BW) : 1;
  logic [IW-1:0]   byte_idx;
  logic [XLEN-1:0] asm_q;
  // lanes above byte_idx are always zero in asm_q, so a short last word comes out zero-padded
  always_comb begin
    word = asm_q | (XLEN'(data) << {byte_idx, 3'b000});
    wr = accept & (last | (byte_idx == IW'(BW - 1)));
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      byte_idx <= '0;
      asm_q <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      asm_q <= '0;
    end else if (accept) begin
      byte_idx <= wr ? '0 : byte_idx + 1'b1;
      asm_q <= wr ? '0 : word;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a byte-stream loader port and a registered fetch port.
module imem_loader #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 256,
  parameter logic [XLEN-1:0] NOP_WORD  = XLEN'(imem_pkg::NOP_WORD),
  parameter string           INIT_FILE = "imem.hex"
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       ld_start,
  input  logic                       ld_byte_valid,
  input  logic [7:0]                 ld_byte,
  input  logic                       ld_last,
  output logic                       ld_byte_ready,
  output logic                       ld_busy,
  output logic                       ld_done,
  output logic [$clog2(DEPTH):0]     ld_count,
  input  logic                       fetch_req,
  input  logic [XLEN-1:0]            fetch_addr,
  output logic                       fetch_valid,
  output logic [XLEN-1:0]            fetch_instr,
  output logic                       fetch_fault
);
  import imem_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
`ifdef IMEM_PRELOAD_EN
  localparam state_t      RST_STATE = DONE;
  localparam logic [AW:0] RST_COUNT = FULL;
`else
  localparam state_t      RST_STATE = IDLE;
  localparam logic [AW:0] RST_COUNT = '0;
`endif
  state_t          state, next;
  logic [AW:0]     count;
  logic            accept, wr, fetch_go, bad;
  logic [XLEN-1:0] word;
  logic [XLEN-1:0] mem [DEPTH];
`ifdef IMEM_PRELOAD_EN
  initial for (int i = 0; i < DEPTH; i++) mem[i] = NOP_WORD;
`endif
  imem_byte_assembler #(.XLEN(XLEN)) u_asm (
    .clock(clock), .reset_n(reset_n), .clear(ld_start), .accept(accept),
    .data(ld_byte), .last(ld_last), .word(word), .wr(wr)
  );
  always_comb begin
    ld_byte_ready = state == LOAD;
    ld_busy = state == LOAD;
    ld_done = state == DONE;
    ld_count = count;
    accept = ld_byte_valid & ld_byte_ready & ~ld_start;
    fetch_go = fetch_req & ~ld_busy & ~ld_start;
    bad = (|fetch_addr[1:0]) | (fetch_addr[XLEN-1:2] >= (XLEN - 2)'(DEPTH));
    next = ld_start ? LOAD : (wr && (ld_last || count + 1'b1 == FULL)) ? DONE : state;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= RST_STATE;
      count <= RST_COUNT;
    end else begin
      state <= next;
      count <= ld_start ? '0 : wr ? count + 1'b1 : count;
    end
  always_ff @(posedge clock)
    if (wr) mem[count[AW-1:0]] <= word;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_instr <= NOP_WORD;
    end else begin
      fetch_valid <= fetch_go;
      if (fetch_go) begin
        fetch_fault <= bad;
        fetch_instr <= bad ? NOP_WORD : mem[fetch_addr[AW+1:2]];
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven fetch vectors checked through a scoreboard, plus loader corner-case sequences.
module tb_imem_loader;
  localparam int DEPTH = 4;
  logic        clock = 1'b0;
  logic        reset_n, ld_start, ld_byte_valid, ld_last, fetch_req;
  logic [7:0]  ld_byte;
  logic [31:0] fetch_addr;
  logic        ld_byte_ready, ld_busy, ld_done, fetch_valid, fetch_fault;
  logic [2:0]  ld_count;
  logic [31:0] fetch_instr;
  int total = 0;
  int bad = 0;
  typedef struct {logic [31:0] addr; logic [31:0] instr; logic fault;} fvec_t;
  typedef struct {logic [31:0] instr; logic fault;} exp_t;
  exp_t sbq[$];
  fvec_t vecs[6];

  imem_loader #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .ld_start(ld_start), .ld_byte_valid(ld_byte_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_byte_ready(ld_byte_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_count(ld_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock)
    if (fetch_valid === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_fetch_valid", 32'(fetch_valid), 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("fetch_instr", fetch_instr, e.instr);
        chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
      end
    end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    ld_byte_valid = 1'b1;
    ld_byte = b;
    ld_last = l;
    step();
    ld_byte_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] i, input logic f);
    exp_t e;
    e.instr = i;
    e.fault = f;
    fetch_req = 1'b1;
    fetch_addr = a;
    sbq.push_back(e);
    step();
    fetch_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sbq.size() != 0; i++) step();
    step();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic run_fetches(input fvec_t v[6], input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.instr = v[i].instr;
      e.fault = v[i].fault;
      fetch_req = 1'b1;
      fetch_addr = v[i].addr;
      sbq.push_back(e);
      step();
    end
    fetch_req = 1'b0;
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    {ld_start, ld_byte_valid, ld_last, fetch_req} = '0;
    ld_byte = '0;
    fetch_addr = '0;
    step();
    step();
    chk("rst_ready", 32'(ld_byte_ready), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_count", 32'(ld_count), 32'd0);
    chk("rst_fvalid", 32'(fetch_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_instr", fetch_instr, 32'h13);
    reset_n = 1'b1;
    step();
    start();
    chk("load_busy", 32'(ld_busy), 32'd1);
    chk("load_ready", 32'(ld_byte_ready), 32'd1);
    send(8'hB3, 0); send(8'h00, 0); send(8'hA2, 0); send(8'h00, 0);
    chk("count_1", 32'(ld_count), 32'd1);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 1);
    chk("count_2", 32'(ld_count), 32'd2);
    chk("done_2", 32'(ld_done), 32'd1);
    chk("ready_done", 32'(ld_byte_ready), 32'd0);
    chk("busy_done", 32'(ld_busy), 32'd0);
    vecs[0] = '{32'd0, 32'h00A200B3, 1'b0};
    vecs[1] = '{32'd4, 32'h00000013, 1'b0};
    vecs[2] = '{32'd1, 32'h00000013, 1'b1};
    vecs[3] = '{32'(4 * DEPTH), 32'h00000013, 1'b1};
    vecs[4] = '{32'd2, 32'h00000013, 1'b1};
    vecs[5] = '{32'd0, 32'h00A200B3, 1'b0};
    run_fetches(vecs, 6);
    // fetch requests in the ld_start cycle and during LOAD produce nothing
    fetch_req = 1'b1;
    fetch_addr = 32'd0;
    start();
    chk("fvalid_start", 32'(fetch_valid), 32'd0);
    step();
    chk("fvalid_load", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0;
    send(8'h11, 0); send(8'h22, 1);
    chk("pad_count", 32'(ld_count), 32'd1);
    chk("pad_done", 32'(ld_done), 32'd1);
    fetch(32'd0, 32'h00002211, 1'b0);
    fetch(32'd4, 32'h00000013, 1'b0);
    drain();
    start();
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    chk("full_done", 32'(ld_done), 32'd1);
    chk("full_count", 32'(ld_count), 32'd4);
    chk("full_ready", 32'(ld_byte_ready), 32'd0);
    send(8'hEE, 1);
    chk("full_count_after", 32'(ld_count), 32'd4);
    vecs[0] = '{32'd0, 32'h03020100, 1'b0};
    vecs[1] = '{32'd4, 32'h07060504, 1'b0};
    vecs[2] = '{32'd8, 32'h0B0A0908, 1'b0};
    vecs[3] = '{32'd12, 32'h0F0E0D0C, 1'b0};
    vecs[4] = '{32'd13, 32'h00000013, 1'b1};
    vecs[5] = '{32'd20, 32'h00000013, 1'b1};
    run_fetches(vecs, 6);
    start();
    send(8'hAA, 0); send(8'hBB, 0);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(ld_busy), 32'd0);
    chk("arst_ready", 32'(ld_byte_ready), 32'd0);
    chk("arst_count", 32'(ld_count), 32'd0);
    chk("arst_instr", fetch_instr, 32'h13);
    step();
    reset_n = 1'b1;
    step();
    start();
    send(8'h99, 0);
    ld_byte_valid = 1'b1;
    ld_byte = 8'h88;
    start();
    ld_byte_valid = 1'b0;
    chk("restart_count", 32'(ld_count), 32'd0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h55, 1);
    chk("fresh_count", 32'(ld_count), 32'd2);
    fetch(32'd0, 32'h04030201, 1'b0);
    fetch(32'd4, 32'h00000055, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
